instr_decode_stage: RTL and testbench

//  Registered, parametrised instruction-decode pipeline stage between fetch and execute.

---
 rtl/cpu_isa_pkg.sv | 71 +++++++
 rtl/opcode_decode_comb.sv | 73 +++++++
 rtl/instr_decode_stage.sv | 142 ++++++++++++++
 tb/tb_instr_decode_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - opcode map, ALU function encodings and control-bundle layout
package cpu_isa_pkg;

    localparam int CTRL_W = 16;

    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_SUBI = 5'b01101;
    localparam logic [4:0] OP_MULT = 5'b00110;
    localparam logic [4:0] OP_MULTI = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b00111;
    localparam logic [4:0] OP_DIVI = 5'b01111;
    localparam logic [4:0] OP_AND  = 5'b00001;
    localparam logic [4:0] OP_ANDI = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_ORI  = 5'b01010;
    localparam logic [4:0] OP_XOR  = 5'b00011;
    localparam logic [4:0] OP_BGT  = 5'b10000;
    localparam logic [4:0] OP_SLT  = 5'b10001;
    localparam logic [4:0] OP_LW   = 5'b10010;
    localparam logic [4:0] OP_SW   = 5'b10011;
    localparam logic [4:0] OP_BEQ  = 5'b10100;
    localparam logic [4:0] OP_BNE  = 5'b10101;
    localparam logic [4:0] OP_JR   = 5'b10110;
    localparam logic [4:0] OP_J    = 5'b10111;

    localparam logic [2:0] ALU_FN_ADD  = 3'd0;
    localparam logic [2:0] ALU_FN_SUB  = 3'd1;
    localparam logic [2:0] ALU_FN_MULT = 3'd2;
    localparam logic [2:0] ALU_FN_DIV  = 3'd3;
    localparam logic [2:0] ALU_FN_AND  = 3'd4;
    localparam logic [2:0] ALU_FN_OR   = 3'd5;
    localparam logic [2:0] ALU_FN_XOR  = 3'd6;
    localparam logic [2:0] ALU_FN_NONE = 3'd7;

    // Bit positions inside the control bundle; alu_op occupies [4:0].
    localparam int CTRL_ILLEGAL = 15;
    localparam int CTRL_IMM     = 14;
    localparam int CTRL_R_TYPE  = 13;
    localparam int CTRL_BGT     = 12;
    localparam int CTRL_SLT     = 11;
    localparam int CTRL_LW      = 10;
    localparam int CTRL_SW      = 9;
    localparam int CTRL_BEQ     = 8;
    localparam int CTRL_BNE     = 7;
    localparam int CTRL_JR      = 6;
    localparam int CTRL_J       = 5;
    localparam int ALU_OP_ARITH = 0;
    localparam int ALU_OP_SLT   = 1;
    localparam int ALU_OP_MEM   = 2;
    localparam int ALU_OP_BR    = 3;
    localparam int ALU_OP_JR    = 4;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // Register and immediate forms share the low three opcode bits.
    function automatic logic [2:0] arith_alu_fn(input logic [2:0] low3);
        case (low3)
            3'b100:  return ALU_FN_ADD;
            3'b101:  return ALU_FN_SUB;
            3'b110:  return ALU_FN_MULT;
            3'b111:  return ALU_FN_DIV;
            3'b001:  return ALU_FN_AND;
            3'b010:  return ALU_FN_OR;
            3'b011:  return ALU_FN_XOR;
            default: return ALU_FN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/opcode_decode_comb.sv
// rtl/opcode_decode_comb.sv - combinational opcode to {ctrl, alu_fn} decoder
module opcode_decode_comb
    import cpu_isa_pkg::*;
#(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0] i_opcode,
    output ctrl_t           o_ctrl,
    output logic [2:0]      o_alu_fn
);

    logic       w_hi_nz;
    logic [4:0] w_op5;

    generate
        if (OP_W > 5) begin : g_wide
            assign w_hi_nz = |i_opcode[OP_W-1:5];
        end else begin : g_narrow
            assign w_hi_nz = 1'b0;
        end
    endgenerate

    assign w_op5 = i_opcode[4:0];

    always_comb begin
        o_ctrl   = '0;
        o_alu_fn = ALU_FN_NONE;
        if (w_hi_nz) begin
            o_ctrl[CTRL_ILLEGAL] = 1'b1;
        end else begin
            case (w_op5)
                OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_AND, OP_OR, OP_XOR: begin
                    o_ctrl[CTRL_R_TYPE]  = 1'b1;
                    o_ctrl[ALU_OP_ARITH] = 1'b1;
                    o_alu_fn             = arith_alu_fn(w_op5[2:0]);
                end
                OP_ADDI, OP_SUBI, OP_MULTI, OP_DIVI, OP_ANDI, OP_ORI: begin
                    o_ctrl[CTRL_IMM]     = 1'b1;
                    o_ctrl[ALU_OP_ARITH] = 1'b1;
                    o_alu_fn             = arith_alu_fn(w_op5[2:0]);
                end
                OP_BGT: o_ctrl[CTRL_BGT] = 1'b1;
                OP_SLT: begin
                    o_ctrl[CTRL_SLT]   = 1'b1;
                    o_ctrl[ALU_OP_SLT] = 1'b1;
                end
                OP_LW: begin
                    o_ctrl[CTRL_LW]    = 1'b1;
                    o_ctrl[ALU_OP_MEM] = 1'b1;
                end
                OP_SW: begin
                    o_ctrl[CTRL_SW]    = 1'b1;
                    o_ctrl[ALU_OP_MEM] = 1'b1;
                end
                OP_BEQ: begin
                    o_ctrl[CTRL_BEQ]  = 1'b1;
                    o_ctrl[ALU_OP_BR] = 1'b1;
                end
                OP_BNE: begin
                    o_ctrl[CTRL_BNE]  = 1'b1;
                    o_ctrl[ALU_OP_BR] = 1'b1;
                end
                OP_JR: begin
                    o_ctrl[CTRL_JR]   = 1'b1;
                    o_ctrl[ALU_OP_JR] = 1'b1;
                end
                OP_J:    o_ctrl[CTRL_J] = 1'b1;
                default: o_ctrl[CTRL_ILLEGAL] = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered decode stage; DECODE_SKID_EN adds a skid entry
module instr_decode_stage
    import cpu_isa_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OP_W    = 5,
    parameter int OP_LSB  = 27,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [INSTR_W-1:0] i_in_instr,
    input  logic [PC_W-1:0]    i_in_pc,
    input  logic               i_flush,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [INSTR_W-1:0] o_out_instr,
    output logic [PC_W-1:0]    o_out_pc,
    output logic [CTRL_W-1:0]  o_out_ctrl,
    output logic [2:0]         o_out_alu_fn,
    output logic [CNT_W-1:0]   o_decoded_cnt
);

    ctrl_t              w_dec_ctrl;
    logic [2:0]         w_dec_alu_fn;
    logic               w_accept;
    logic               w_out_hs;
    logic               w_load_out;

    logic               r_out_valid;
    logic [INSTR_W-1:0] r_out_instr;
    logic [PC_W-1:0]    r_out_pc;
    ctrl_t              r_out_ctrl;
    logic [2:0]         r_out_alu_fn;
    logic [CNT_W-1:0]   r_cnt;

    opcode_decode_comb #(
        .OP_W (OP_W)
    ) u_opcode_decode (
        .i_opcode (i_in_instr[OP_LSB +: OP_W]),
        .o_ctrl   (w_dec_ctrl),
        .o_alu_fn (w_dec_alu_fn)
    );

    assign w_accept   = i_in_valid & o_in_ready;
    assign w_out_hs   = r_out_valid & i_out_ready;
    assign w_load_out = !r_out_valid | i_out_ready;

`ifdef DECODE_SKID_EN
    logic               r_skid_valid;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [PC_W-1:0]    r_skid_pc;
    ctrl_t              r_skid_ctrl;
    logic [2:0]         r_skid_alu_fn;

    assign o_in_ready = !r_skid_valid;

    // The skid only fills while the output is stalled, so a full skid implies a full output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid   <= 1'b0;
            r_out_instr   <= '0;
            r_out_pc      <= '0;
            r_out_ctrl    <= '0;
            r_out_alu_fn  <= ALU_FN_NONE;
            r_skid_valid  <= 1'b0;
            r_skid_instr  <= '0;
            r_skid_pc     <= '0;
            r_skid_ctrl   <= '0;
            r_skid_alu_fn <= ALU_FN_NONE;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_load_out) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_instr  <= r_skid_instr;
                r_out_pc     <= r_skid_pc;
                r_out_ctrl   <= r_skid_ctrl;
                r_out_alu_fn <= r_skid_alu_fn;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out_instr  <= i_in_instr;
                    r_out_pc     <= i_in_pc;
                    r_out_ctrl   <= w_dec_ctrl;
                    r_out_alu_fn <= w_dec_alu_fn;
                end
            end
        end else if (w_accept) begin
            r_skid_valid  <= 1'b1;
            r_skid_instr  <= i_in_instr;
            r_skid_pc     <= i_in_pc;
            r_skid_ctrl   <= w_dec_ctrl;
            r_skid_alu_fn <= w_dec_alu_fn;
        end
    end
`else
    assign o_in_ready = !r_out_valid | i_out_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= '0;
            r_out_pc     <= '0;
            r_out_ctrl   <= '0;
            r_out_alu_fn <= ALU_FN_NONE;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load_out) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_instr  <= i_in_instr;
                r_out_pc     <= i_in_pc;
                r_out_ctrl   <= w_dec_ctrl;
                r_out_alu_fn <= w_dec_alu_fn;
            end
        end
    end
`endif

    // A beat leaving in the flush cycle was delivered, so it still counts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_out_hs) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_out_valid   = r_out_valid;
    assign o_out_instr   = r_out_instr;
    assign o_out_pc      = r_out_pc;
    assign o_out_ctrl    = r_out_ctrl;
    assign o_out_alu_fn  = r_out_alu_fn;
    assign o_decoded_cnt = r_cnt;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - table-driven bench for instr_decode_stage (OP_W=6, CNT_W=4)
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [15:0] out_ctrl;
    logic [2:0]  out_alu_fn;
    logic [3:0]  dcnt;

    int n_pass  = 0;
    int n_total = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [5:0]  op;
        logic [15:0] ctrl;
        logic [2:0]  fn;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    instr_decode_stage #(
        .INSTR_W (32),
        .OP_W    (6),
        .OP_LSB  (26),
        .PC_W    (32),
        .CNT_W   (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_instr    (in_instr),
        .i_in_pc       (in_pc),
        .i_flush       (flush),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_instr   (out_instr),
        .o_out_pc      (out_pc),
        .o_out_ctrl    (out_ctrl),
        .o_out_alu_fn  (out_alu_fn),
        .o_decoded_cnt (dcnt)
    );

    function automatic logic [31:0] mk_instr(input logic [5:0] op, input int tag);
        logic [31:0] t;
        t = tag;
        return {op, t[25:0]};
    endfunction

    function automatic logic [31:0] mk_pc(input int tag);
        return 32'h1000 + 32'(tag) * 32'd4;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input int tag);
        in_valid = v;
        in_instr = mk_instr(op, tag);
        in_pc    = mk_pc(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_valid"}, 64'(out_valid), 64'(0));
        chk({pfx, "_ready"}, 64'(in_ready), 64'(1));
        chk({pfx, "_cnt"}, 64'(dcnt), 64'(0));
        chk({pfx, "_ctrl"}, 64'(out_ctrl), 64'(0));
        chk({pfx, "_fn"}, 64'(out_alu_fn), 64'(7));
        chk({pfx, "_instr"}, 64'(out_instr), 64'(0));
        chk({pfx, "_pc"}, 64'(out_pc), 64'(0));
    endtask

    // Back-to-back stream with out_ready=1: each beat must appear exactly one cycle after accept.
    task automatic stream(input int start, input int n);
        out_ready = 1'b1;
        flush     = 1'b0;
        drive(1'b1, vecs[start % NV].op, start);
        for (int k = 0; k < n; k++) begin
            int tag;
            int idx;
            tick();
            tag = start + k;
            idx = tag % NV;
            chk("str_valid", 64'(out_valid), 64'(1));
            chk("str_ready", 64'(in_ready), 64'(1));
            chk("str_instr", 64'(out_instr), 64'(mk_instr(vecs[idx].op, tag)));
            chk("str_pc", 64'(out_pc), 64'(mk_pc(tag)));
            chk("str_ctrl", 64'(out_ctrl), 64'(vecs[idx].ctrl));
            chk("str_fn", 64'(out_alu_fn), 64'(vecs[idx].fn));
            if (k < n - 1) drive(1'b1, vecs[(tag + 1) % NV].op, tag + 1);
            else in_valid = 1'b0;
        end
        tick();
        chk("str_drain", 64'(out_valid), 64'(0));
        exp_cnt = (exp_cnt + n) % 16;
        chk("str_cnt", 64'(dcnt), 64'(exp_cnt));
    endtask

    initial begin
        vecs[0]  = '{6'b000100, 16'h2001, 3'd0};
        vecs[1]  = '{6'b001100, 16'h4001, 3'd0};
        vecs[2]  = '{6'b000101, 16'h2001, 3'd1};
        vecs[3]  = '{6'b001101, 16'h4001, 3'd1};
        vecs[4]  = '{6'b000110, 16'h2001, 3'd2};
        vecs[5]  = '{6'b001110, 16'h4001, 3'd2};
        vecs[6]  = '{6'b000111, 16'h2001, 3'd3};
        vecs[7]  = '{6'b001111, 16'h4001, 3'd3};
        vecs[8]  = '{6'b000001, 16'h2001, 3'd4};
        vecs[9]  = '{6'b001001, 16'h4001, 3'd4};
        vecs[10] = '{6'b000010, 16'h2001, 3'd5};
        vecs[11] = '{6'b001010, 16'h4001, 3'd5};
        vecs[12] = '{6'b000011, 16'h2001, 3'd6};
        vecs[13] = '{6'b010000, 16'h1000, 3'd7};
        vecs[14] = '{6'b010001, 16'h0802, 3'd7};
        vecs[15] = '{6'b010010, 16'h0404, 3'd7};
        vecs[16] = '{6'b010011, 16'h0204, 3'd7};
        vecs[17] = '{6'b010100, 16'h0108, 3'd7};
        vecs[18] = '{6'b010101, 16'h0088, 3'd7};
        vecs[19] = '{6'b010110, 16'h0050, 3'd7};
        vecs[20] = '{6'b010111, 16'h0020, 3'd7};
        vecs[21] = '{6'b000000, 16'h8000, 3'd7};
        vecs[22] = '{6'b001000, 16'h8000, 3'd7};
        vecs[23] = '{6'b011111, 16'h8000, 3'd7};
        vecs[24] = '{6'b100100, 16'h8000, 3'd7};
        vecs[25] = '{6'b001011, 16'h8000, 3'd7};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2;
        chk_reset_vals("rst0");
        @(negedge clk);
        rst = 1'b0;
        tick();

        stream(0, NV);

        // Backpressure: A in output, B held (skid) or still presented (no skid).
        out_ready = 1'b0;
        drive(1'b1, 6'b000100, 200);
        tick();
        chk("bp_a_valid", 64'(out_valid), 64'(1));
        chk("bp_a_instr", 64'(out_instr), 64'(mk_instr(6'b000100, 200)));
        drive(1'b1, 6'b001101, 201);
        tick();
        chk("bp_hold_ready", 64'(in_ready), 64'(0));
        chk("bp_hold_instr", 64'(out_instr), 64'(mk_instr(6'b000100, 200)));
        tick();
        chk("bp_hold2_ready", 64'(in_ready), 64'(0));
        chk("bp_hold2_instr", 64'(out_instr), 64'(mk_instr(6'b000100, 200)));
        chk("bp_hold2_ctrl", 64'(out_ctrl), 64'(16'h2001));
`ifdef DECODE_SKID_EN
        in_valid = 1'b0;
`endif
        out_ready = 1'b1;
        tick();
        chk("bp_b_valid", 64'(out_valid), 64'(1));
        chk("bp_b_instr", 64'(out_instr), 64'(mk_instr(6'b001101, 201)));
        chk("bp_b_ctrl", 64'(out_ctrl), 64'(16'h4001));
        chk("bp_b_fn", 64'(out_alu_fn), 64'(1));
        in_valid = 1'b0;
        tick();
        chk("bp_empty", 64'(out_valid), 64'(0));
        exp_cnt = (exp_cnt + 2) % 16;
        chk("bp_cnt", 64'(dcnt), 64'(exp_cnt));

        // Flush with held beats and one incoming beat, output stalled.
        out_ready = 1'b0;
        drive(1'b1, 6'b000100, 300);
        tick();
        drive(1'b1, 6'b000101, 301);
        tick();
        drive(1'b1, 6'b010111, 302);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'(0));
        chk("fl_ready", 64'(in_ready), 64'(1));
        chk("fl_cnt", 64'(dcnt), 64'(exp_cnt));
        tick();
        chk("fl_valid2", 64'(out_valid), 64'(0));

        // Flush while the output handshakes: X delivered and counted, Y discarded.
        out_ready = 1'b1;
        drive(1'b1, 6'b010010, 310);
        tick();
        chk("fl2_x_instr", 64'(out_instr), 64'(mk_instr(6'b010010, 310)));
        drive(1'b1, 6'b010011, 311);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl2_valid", 64'(out_valid), 64'(0));
        exp_cnt = (exp_cnt + 1) % 16;
        chk("fl2_cnt", 64'(dcnt), 64'(exp_cnt));
        tick();
        chk("fl2_valid2", 64'(out_valid), 64'(0));

        // Asynchronous reset in the middle of a stream.
        out_ready = 1'b1;
        drive(1'b1, 6'b000100, 400);
        tick();
        drive(1'b1, 6'b000101, 401);
        tick();
        exp_cnt = (exp_cnt + 1) % 16;
        chk("pre_rst_cnt", 64'(dcnt), 64'(exp_cnt));
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk_reset_vals("arst");
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 17 handshakes on a 4-bit counter wrap it to 1.
        stream(500, 17);
        chk("cnt_wrap", 64'(dcnt), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
